// File: rtl/vgm_ahb_types_pkg.sv
// Shared AHB type definitions for the bus arbiter and its bench.
// burst_len() gives the fixed beat count of a burst, or 0 for undefined-length/single.
package vgm_ahb_types_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_e;

  typedef enum logic [2:0] {
    SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
  } hburst_e;

  typedef enum logic [1:0] {OKAY, ERROR, RETRY, SPLIT} hresp_e;

  function automatic logic [4:0] burst_len(hburst_e b);
    unique case (b)
      WRAP4,  INCR4:  return 5'd4;
      WRAP8,  INCR8:  return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vgm_ahb_arbiter_if.sv
// Arbitration signals between the masters/bus fabric and the AHB arbiter.
// master: the fabric side driving requests and bus status; slave: the arbiter.
interface vgm_ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [1:0]             HRESP;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );

endinterface

// File: rtl/vgm_ahb_rr_picker.sv
// Combinational round-robin picker: first requester searching upward from last+1 with wrap.
// The previous owner is searched last, so it keeps the bus only when nobody else asks.
module vgm_ahb_rr_picker #(
  parameter int N  = 4,
  parameter int MW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [MW-1:0] idx,
  output logic          valid
);

  always_comb begin : pick
    int c;
    c     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = MW'(c);
      end
    end
  end

endmodule

// File: rtl/vgm_ahb_arbiter.sv
// Round-robin AHB arbiter: freezes the grant inside fixed-length bursts and locked
// sequences, parks on DEFAULT_MASTER, tracks the address-phase owner on HREADY.
module vgm_ahb_arbiter
  import vgm_ahb_types_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input logic              HCLK,
  input logic              HRESET,
  vgm_ahb_arbiter_if.slave bus
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCK} state_e;

  state_e                 state, state_nxt;
  logic [3:0]             beats_left, beats_nxt;
  logic [MW-1:0]          last_owner, owner, hmaster, pick_idx;
  logic [NUM_MASTERS-1:0] hgrant, pick_gnt;
  logic                   hmastlock, mlock_nxt, pick_vld;
  logic                   arb_open, reopen, hready, xfer_err, start_burst;
  htrans_e                htrans;
  logic [4:0]             blen;

  assign hready      = bus.HREADY;
  assign htrans      = htrans_e'(bus.HTRANS);
  assign blen        = burst_len(hburst_e'(bus.HBURST));
  assign xfer_err    = hready && (hresp_e'(bus.HRESP) == ERROR);
  assign start_burst = hready && (htrans == NONSEQ) && (blen != 5'd0);

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (hgrant[i]) owner = MW'(i);
  end

  assign mlock_nxt = hready ? bus.HLOCK[owner] : hmastlock;

  vgm_ahb_rr_picker #(.N(NUM_MASTERS), .MW(MW)) u_pick (
    .req   (bus.HBUSREQ),
    .last  (last_owner),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // reopen: the ARB load/lock rules apply this cycle (steady ARB, last beat, early end)
  always_comb begin
    state_nxt = state;
    beats_nxt = beats_left;
    arb_open  = 1'b0;
    reopen    = 1'b0;
    unique case (state)
      ST_ARB: reopen = 1'b1;
      ST_BURST:
        if (hready) begin
          unique case (htrans)
            SEQ:
              if (beats_left <= 4'd1) begin
                beats_nxt = '0;
                reopen    = 1'b1;
              end else begin
                beats_nxt = beats_left - 4'd1;
              end
            IDLE, NONSEQ: begin
              beats_nxt = '0;
              reopen    = 1'b1;
            end
            default: ;
          endcase
        end
      ST_LOCK:
        if (hready && !bus.HLOCK[owner]) state_nxt = ST_ARB;
      default: state_nxt = ST_ARB;
    endcase

    if (reopen) begin
      if (mlock_nxt) begin
        state_nxt = ST_LOCK;
      end else if (start_burst) begin
        state_nxt = ST_BURST;
        beats_nxt = 4'(blen - 5'd1);
      end else begin
        state_nxt = ST_ARB;
        arb_open  = 1'b1;
      end
    end

    if (xfer_err) begin
      state_nxt = ST_ARB;
      beats_nxt = '0;
      arb_open  = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_ARB;
      beats_left <= '0;
      last_owner <= DEF_IDX;
      hgrant     <= DEF_GNT;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_nxt;
      if (arb_open) begin
        if (pick_vld) begin
          hgrant     <= pick_gnt;
          last_owner <= pick_idx;
        end else begin
          hgrant     <= DEF_GNT;
        end
      end
      // address phase moves to whoever held the grant during an HREADY-high cycle
      if (hready) begin
        hmaster   <= owner;
        hmastlock <= bus.HLOCK[owner];
      end
    end
  end

  assign bus.HGRANT    = hgrant;
  assign bus.HMASTER   = hmaster;
  assign bus.HMASTLOCK = hmastlock;

endmodule

// File: tb/tb_vgm_ahb_arbiter.sv
// Scenario bench for vgm_ahb_arbiter: each cycle pushes the expected grant/owner/lock,
// a monitor pops and compares just after the following rising edge.
module tb_vgm_ahb_arbiter;
  import vgm_ahb_types_pkg::*;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  exp_t  eq[$];
  string tq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  vgm_ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

  vgm_ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of bus inputs and record what the outputs must be after its edge
  task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] lck,
                     input htrans_e tr, input hburst_e bu,
                     input logic [3:0] eg, input logic [1:0] em, input logic el);
    exp_t e;
    bus.HBUSREQ = req;
    bus.HLOCK   = lck;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    e.g = eg; e.m = em; e.l = el;
    eq.push_back(e);
    tq.push_back(tag);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t  e;
    string t;
    #1;
    if (eq.size() != 0) begin
      e = eq.pop_front();
      t = tq.pop_front();
      chk({t, ".grant"},  int'(bus.HGRANT),    int'(e.g));
      chk({t, ".master"}, int'(bus.HMASTER),   int'(e.m));
      chk({t, ".lock"},   int'(bus.HMASTLOCK), int'(e.l));
    end
  end

  initial begin
    rst        = 1'b1;
    bus.HREADY = 1'b1;
    bus.HRESP  = OKAY;

    // reset holds the default master regardless of requests
    cyc("rst", 4'b1111, 4'b0, IDLE, SINGLE, 4'b0001, 2'd0, 1'b0);
    cyc("rst", 4'b1111, 4'b0, IDLE, SINGLE, 4'b0001, 2'd0, 1'b0);
    rst = 1'b0;

    // round robin between masters 1 and 3, owner lags grant by one cycle
    cyc("rr", 4'b1010, 4'b0, NONSEQ, SINGLE, 4'b0010, 2'd0, 1'b0);
    cyc("rr", 4'b1010, 4'b0, NONSEQ, SINGLE, 4'b1000, 2'd1, 1'b0);
    cyc("rr", 4'b1010, 4'b0, NONSEQ, SINGLE, 4'b0010, 2'd3, 1'b0);
    cyc("rr", 4'b1010, 4'b0, NONSEQ, SINGLE, 4'b1000, 2'd1, 1'b0);

    // INCR4 by master 2, master 0 waiting
    cyc("i4",  4'b0100, 4'b0, IDLE,   SINGLE, 4'b0100, 2'd3, 1'b0);
    cyc("i4",  4'b0100, 4'b0, IDLE,   SINGLE, 4'b0100, 2'd2, 1'b0);
    cyc("i4b1", 4'b0101, 4'b0, NONSEQ, INCR4, 4'b0100, 2'd2, 1'b0);
    cyc("i4b2", 4'b0101, 4'b0, SEQ,    INCR4, 4'b0100, 2'd2, 1'b0);
    cyc("i4b3", 4'b0101, 4'b0, SEQ,    INCR4, 4'b0100, 2'd2, 1'b0);
    cyc("i4b4", 4'b0101, 4'b0, SEQ,    INCR4, 4'b0001, 2'd2, 1'b0);
    cyc("i4ho", 4'b0001, 4'b0, IDLE,   SINGLE, 4'b0001, 2'd0, 1'b0);

    // WRAP8 by master 3 with a 3-cycle wait state at beat 2
    cyc("w8",   4'b1000, 4'b0, IDLE,   SINGLE, 4'b1000, 2'd0, 1'b0);
    cyc("w8",   4'b1000, 4'b0, IDLE,   SINGLE, 4'b1000, 2'd3, 1'b0);
    cyc("w8b1", 4'b1001, 4'b0, NONSEQ, WRAP8,  4'b1000, 2'd3, 1'b0);
    bus.HREADY = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("w8wait", 4'b1001, 4'b0, SEQ, WRAP8, 4'b1000, 2'd3, 1'b0);
    bus.HREADY = 1'b1;
    for (int i = 2; i <= 7; i++)
      cyc("w8mid", 4'b1001, 4'b0, SEQ, WRAP8, 4'b1000, 2'd3, 1'b0);
    cyc("w8b8", 4'b1001, 4'b0, SEQ,  WRAP8,  4'b0001, 2'd3, 1'b0);
    cyc("w8ho", 4'b0001, 4'b0, IDLE, SINGLE, 4'b0001, 2'd0, 1'b0);

    // locked sequence by master 1 while everyone requests
    cyc("lk", 4'b1111, 4'b0010, NONSEQ, SINGLE, 4'b0010, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc("lkhold", 4'b1111, 4'b0010, NONSEQ, SINGLE, 4'b0010, 2'd1, 1'b1);
    cyc("lkdrop", 4'b1111, 4'b0000, NONSEQ, SINGLE, 4'b0010, 2'd1, 1'b0);
    cyc("lkrel",  4'b1111, 4'b0000, NONSEQ, SINGLE, 4'b0100, 2'd1, 1'b0);
    cyc("lknext", 4'b1000, 4'b0000, IDLE,   SINGLE, 4'b1000, 2'd2, 1'b0);

    // ERROR aborts INCR16 of master 3
    cyc("er",   4'b1000, 4'b0, IDLE,   SINGLE, 4'b1000, 2'd3, 1'b0);
    cyc("erb1", 4'b1011, 4'b0, NONSEQ, INCR16, 4'b1000, 2'd3, 1'b0);
    bus.HRESP = ERROR;
    cyc("erb2", 4'b1011, 4'b0, SEQ,    INCR16, 4'b0001, 2'd3, 1'b0);
    bus.HRESP = OKAY;
    cyc("erho", 4'b0010, 4'b0, IDLE,   SINGLE, 4'b0010, 2'd0, 1'b0);

    // reset in the middle of an INCR8 by master 1 abandons the burst
    cyc("rb",   4'b0010, 4'b0, IDLE,   SINGLE, 4'b0010, 2'd1, 1'b0);
    cyc("rbb1", 4'b0011, 4'b0, NONSEQ, INCR8,  4'b0010, 2'd1, 1'b0);
    cyc("rbb2", 4'b0011, 4'b0, SEQ,    INCR8,  4'b0010, 2'd1, 1'b0);
    rst = 1'b1;
    cyc("rbrst", 4'b0011, 4'b0, SEQ,   INCR8,  4'b0001, 2'd0, 1'b0);
    rst = 1'b0;
    cyc("rbarb", 4'b0011, 4'b0, IDLE,  SINGLE, 4'b0010, 2'd0, 1'b0);

    // parking on the default master leaves the round-robin pointer alone
    cyc("park", 4'b0000, 4'b0, IDLE, SINGLE, 4'b0001, 2'd1, 1'b0);
    cyc("ptr",  4'b0011, 4'b0, IDLE, SINGLE, 4'b0001, 2'd0, 1'b0);

    @(posedge clk);
    #2;
    chk("drain", eq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
